bcd_down_timer: RTL

- Loadable multi-digit BCD down-counter: a countdown timer that is the downward counterpart of the team's decade up-counter.
- Decrements a packed BCD value once per enabled tick, borrowing across digits (digit 0 wraps to 9).
- Flags expiry and supports single-shot or auto-reload operation.
- Sits between a tick-enable source (prescaler) and display/control logic that consumes Q, BUSY and DONE.

---
 rtl/bcd_down_timer.sv | 103 ++++++++++
 1 files changed

// File: rtl/bcd_down_timer.sv
// rtl/bcd_down_timer.sv - loadable multi-digit BCD countdown timer with expiry pulse and optional auto-reload
module bcd_down_timer #(
    parameter int DIGITS      = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                LOAD,
    input  logic [4*DIGITS-1:0] LOAD_VAL,
    input  logic                START,
    input  logic                EN,
    output logic [4*DIGITS-1:0] Q,
    output logic                BUSY,
    output logic                TC,
    output logic                DONE
);

    localparam int W = 4 * DIGITS;
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXPIRED
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   q_q, q_d;
    logic [W-1:0]   reload_q, reload_d;
    logic           done_q, done_d;
    logic [W-1:0]   load_clamped;
    logic [W-1:0]   q_dec;
    logic           borrow;

    // Clamp incoming digits to valid BCD and form the digit-wise BCD decrement of Q
    always_comb begin
        load_clamped = '0;
        q_dec        = '0;
        borrow       = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            load_clamped[4*i +: 4] = (LOAD_VAL[4*i +: 4] > 4'd9) ? 4'd9 : LOAD_VAL[4*i +: 4];
            if (!borrow) begin
                q_dec[4*i +: 4] = q_q[4*i +: 4];
            end else if (q_q[4*i +: 4] == 4'd0) begin
                q_dec[4*i +: 4] = 4'd9;
            end else begin
                q_dec[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
                borrow          = 1'b0;
            end
        end
    end

    // Next-state logic: LOAD beats START beats EN; a START that has no effect lets EN through
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (LOAD) begin
            q_d      = load_clamped;
            reload_d = load_clamped;
            state_d  = IDLE;
        end else if (START && (state_q == IDLE) && (q_q != '0)) begin
            state_d = RUN;
        end else if (START && (state_q == EXPIRED) && (reload_q != '0)) begin
            q_d     = reload_q;
            state_d = RUN;
        end else if (EN && (state_q == RUN)) begin
            if (q_q == ONE) begin
                done_d = 1'b1;
                if (AUTO_RELOAD) begin
                    q_d = reload_q;
                end else begin
                    q_d     = '0;
                    state_d = EXPIRED;
                end
            end else begin
                q_d = q_dec;
            end
        end
    end

    // State and datapath registers, updated on the falling clock edge
    always_ff @(negedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            q_q      <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign Q    = q_q;
    assign BUSY = (state_q == RUN);
    assign TC   = (q_q == '0);
    assign DONE = done_q;

endmodule
